// File: rtl/guess_game_ctrl.sv
// Game sequencer for the keypad number-guessing game.
// Optional: define GUESS_REVEAL_EN to show the secret on the display after a loss.
module guess_game_ctrl #(
  parameter int MAX_TRIES = 7,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        seed_we,
  input  logic [11:0] seed,
  output logic [11:0] disp_data,
  output logic [3:0]  disp_tries,
  output logic [1:0]  result,
  output logic        light
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

  localparam logic [3:0] K_SUB = 4'hA;
  localparam logic [3:0] K_BS  = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC;
  localparam logic [3:0] K_NEW = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   ctr_q, ctr_d;
  logic [11:0]   secret_q, secret_d;
  logic [11:0]   guess_q, guess_d;
  logic [11:0]   sub_q, sub_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    tries_q, tries_d;
  logic [1:0]    result_q, result_d;
  logic          light_q, light_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [11:0]   disp_q, disp_d;

  logic key_ev;
  logic is_digit;
  logic new_game;

  function automatic logic [11:0] bcd_inc(
    input logic [11:0] v
  );
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
        end
      end
    end
    return r;
  endfunction

  // seed_we wins over a coincident key event
  assign key_ev   = key_valid && !seed_we;
  assign is_digit = key_code < 4'hA;

  always_comb begin
    state_d  = state_q;
    ctr_d    = bcd_inc(ctr_q);
    secret_d = secret_q;
    guess_d  = guess_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    result_d = result_q;
    light_d  = light_q;
    blink_d  = blink_q;
    disp_d   = disp_q;
    new_game = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (key_ev && key_code == K_NEW) begin
          new_game = 1'b1;
        end
      end
      S_ENTRY: begin
        if (key_ev) begin
          unique case (1'b1)
            is_digit: begin
              if (cnt_q != 2'd3) begin
                guess_d = {guess_q[7:0], key_code};
                cnt_d   = cnt_q + 2'd1;
              end
            end
            key_code == K_BS: begin
              if (cnt_q != 2'd0) begin
                guess_d = {4'h0, guess_q[11:4]};
                cnt_d   = cnt_q - 2'd1;
              end
            end
            key_code == K_CLR: begin
              guess_d = 12'h000;
              cnt_d   = 2'd0;
            end
            key_code == K_SUB: begin
              if (cnt_q == 2'd3) begin
                sub_d   = guess_q;
                state_d = S_CHECK;
              end
            end
            key_code == K_NEW: begin
              new_game = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      S_CHECK: begin
        tries_d = tries_q + 4'd1;
        if (guess_q == secret_q) begin
          result_d = 2'b11;
          state_d  = S_WIN;
        end else begin
          result_d = (guess_q < secret_q) ? 2'b01 : 2'b10;
          if (tries_d == TRIES_MAX) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_ENTRY;
            guess_d = 12'h000;
            cnt_d   = 2'd0;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (key_ev && key_code == K_NEW) begin
          new_game = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (new_game) begin
      secret_d = ctr_q;
      tries_d  = 4'd0;
      guess_d  = 12'h000;
      cnt_d    = 2'd0;
      result_d = 2'b00;
      state_d  = S_ENTRY;
    end

    if (seed_we) begin
      secret_d = seed;
    end

    if (state_d == S_WIN) begin
      if (state_q != S_WIN) begin
        blink_d = '0;
        light_d = 1'b1;
      end else if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        light_d = !light_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end else begin
      blink_d = '0;
      light_d = (state_d == S_ENTRY)
             || (state_d == S_CHECK);
    end

    unique case (state_d)
      S_IDLE, S_ENTRY: disp_d = guess_d;
`ifdef GUESS_REVEAL_EN
      S_LOSE:          disp_d = secret_d;
`endif
      default:         disp_d = sub_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ctr_q    <= 12'h000;
      secret_q <= 12'h000;
      guess_q  <= 12'h000;
      sub_q    <= 12'h000;
      cnt_q    <= 2'd0;
      tries_q  <= 4'd0;
      result_q <= 2'b00;
      light_q  <= 1'b0;
      blink_q  <= '0;
      disp_q   <= 12'h000;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      result_q <= result_d;
      light_q  <= light_d;
      blink_q  <= blink_d;
      disp_q   <= disp_d;
    end
  end

  assign disp_data  = disp_q;
  assign disp_tries = tries_q;
  assign result     = result_q;
  assign light      = light_q;

endmodule
